// File: rtl/block_lock_if.sv
`default_nettype none
// ============================================================================
// Module  : block_lock_if
// Brief   : Gearbox-side inputs and decoder-side outputs of block_lock.
// Revision: 1.0
// ============================================================================
interface block_lock_if;
    logic [193:0] gbox_buffer;
    logic [5:0]   gbox_cnt;
    logic         buffer_dv;
    logic [6:0]   block_offset;
    logic [65:0]  block_o;
    logic         block_dv;
    logic         hdr_err;
    logic         locked;
    logic [6:0]   lock_offset;
    logic [7:0]   relock_cnt;

    modport master (
        output gbox_buffer, gbox_cnt, buffer_dv, block_offset,
        input  block_o, block_dv, hdr_err, locked, lock_offset, relock_cnt
    );

    modport slave (
        input  gbox_buffer, gbox_cnt, buffer_dv, block_offset,
        output block_o, block_dv, hdr_err, locked, lock_offset, relock_cnt
    );
endinterface
`default_nettype wire

// File: rtl/block_lock.sv
`default_nettype none
// ============================================================================
// Module  : block_lock
// Brief   : 66b block extraction and header lock FSM with unlock hysteresis.
// Revision: 1.0
// ============================================================================
module block_lock #(
    parameter int LOCK_GOOD  = 64,
    parameter int UNLOCK_BAD = 16,
    parameter int UNLOCK_WIN = 64
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    block_lock_if.slave bus
);
    localparam logic [7:0] LOCK_GOOD_C  = 8'(LOCK_GOOD);
    localparam logic [7:0] UNLOCK_BAD_C = 8'(UNLOCK_BAD);
    localparam logic [7:0] UNLOCK_WIN_C = 8'(UNLOCK_WIN);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t       state, state_n;
    logic [7:0]   good_cnt, good_n;
    logic [7:0]   win_cnt, win_n;
    logic [7:0]   bad_cnt, bad_n;
    logic [7:0]   relock_cnt, relock_n;
    logic [6:0]   cand_off, cand_n;
    logic [6:0]   lock_off, lock_off_n;

    logic [193:0] buf_q;
    logic [7:0]   h_q;
    logic [6:0]   off_q;
    logic         s1_dv;

    logic [65:0]  block_q;
    logic         hdr_err_q;
    logic         block_dv_q;

    logic [6:0]   eff_off;
    logic [65:0]  blk;
    logic         hv;

    assign eff_off = (state == LOCKED) ? lock_off : bus.block_offset;

    // h is the MSB index of the block; h - 65 is its LSB (0..128).
    assign blk = 66'(buf_q >> (h_q - 8'd65));
    assign hv  = blk[65] ^ blk[64];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= '0;
            h_q   <= '0;
            off_q <= '0;
            s1_dv <= 1'b0;
        end else begin
            s1_dv <= bus.buffer_dv;
            if (bus.buffer_dv) begin
                buf_q <= bus.gbox_buffer;
                h_q   <= 8'd128 - {2'b00, bus.gbox_cnt} + {1'b0, eff_off};
                off_q <= eff_off;
            end
        end
    end

    always_comb begin
        state_n    = state;
        good_n     = good_cnt;
        win_n      = win_cnt;
        bad_n      = bad_cnt;
        relock_n   = relock_cnt;
        cand_n     = cand_off;
        lock_off_n = lock_off;
        if (s1_dv) begin
            case (state)
                HUNT: begin
                    if (hv) begin
                        good_n  = 8'd1;
                        cand_n  = off_q;
                        state_n = CHECK;
                    end
                end
                CHECK: begin
                    if (!hv) begin
                        good_n  = 8'd0;
                        state_n = HUNT;
                    end else begin
                        if (off_q != cand_off) begin
                            good_n = 8'd1;
                            cand_n = off_q;
                        end else begin
                            good_n = good_cnt + 8'd1;
                        end
                        // Locking is only evaluated in CHECK, so LOCK_GOOD=1
                        // still needs the HUNT block plus one CHECK block.
                        if (good_n >= LOCK_GOOD_C) begin
                            state_n    = LOCKED;
                            lock_off_n = cand_n;
                            good_n     = 8'd0;
                            win_n      = 8'd0;
                            bad_n      = 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    win_n = win_cnt + 8'd1;
                    bad_n = bad_cnt + {7'd0, ~hv};
                    if (bad_n == UNLOCK_BAD_C) begin
                        state_n = HUNT;
                        good_n  = 8'd0;
                        win_n   = 8'd0;
                        bad_n   = 8'd0;
                        cand_n  = 7'd0;
                        if (relock_cnt != 8'hFF) begin
                            relock_n = relock_cnt + 8'd1;
                        end
                    end else if (win_n == UNLOCK_WIN_C) begin
                        win_n = 8'd0;
                        bad_n = 8'd0;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= HUNT;
            good_cnt   <= '0;
            win_cnt    <= '0;
            bad_cnt    <= '0;
            relock_cnt <= '0;
            cand_off   <= '0;
            lock_off   <= '0;
            block_q    <= '0;
            hdr_err_q  <= 1'b0;
            block_dv_q <= 1'b0;
        end else begin
            state      <= state_n;
            good_cnt   <= good_n;
            win_cnt    <= win_n;
            bad_cnt    <= bad_n;
            relock_cnt <= relock_n;
            cand_off   <= cand_n;
            lock_off   <= lock_off_n;
            block_dv_q <= 1'b0;
            if (s1_dv) begin
                block_q    <= blk;
                hdr_err_q  <= ~hv;
                // The unlocking block itself is still delivered.
                block_dv_q <= (state == LOCKED) || (state_n == LOCKED);
            end
        end
    end

    assign bus.block_o     = block_q;
    assign bus.block_dv    = block_dv_q;
    assign bus.hdr_err     = hdr_err_q;
    assign bus.locked      = (state == LOCKED);
    assign bus.lock_offset = lock_off;
    assign bus.relock_cnt  = relock_cnt;
endmodule
`default_nettype wire

// File: tb/tb_block_lock.sv
`default_nettype none
// ============================================================================
// Module  : tb_block_lock
// Brief   : Segment table plus reference model scoreboard for block_lock.
// Revision: 1.0
// ============================================================================
module tb_block_lock;
    localparam int LOCK_GOOD  = 64;
    localparam int UNLOCK_BAD = 16;
    localparam int UNLOCK_WIN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    block_lock_if bus ();

    block_lock #(
        .LOCK_GOOD (LOCK_GOOD),
        .UNLOCK_BAD(UNLOCK_BAD),
        .UNLOCK_WIN(UNLOCK_WIN)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic        dv;
        logic [65:0] blk;
        logic        err;
        logic        locked;
        logic [6:0]  lockoff;
        logic [7:0]  relock;
    } exp_t;

    typedef struct {
        int n;
        int off;
        int gc;
        int bad_lo;
        int bad_hi;
        bit exp_locked;
        int exp_lockoff;
        int exp_relock;
    } seg_t;

    exp_t sb[$];
    seg_t segs[10];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: 0 HUNT, 1 CHECK, 2 LOCKED
    int m_state, m_good, m_cand, m_lockoff, m_win, m_bad, m_relock;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_good = 0; m_cand = 0; m_lockoff = 0;
        m_win = 0; m_bad = 0; m_relock = 0;
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_block_o"}, bus.block_o, 66'd0);
        chk({nm, "_block_dv"}, bus.block_dv, 66'd0);
        chk({nm, "_hdr_err"}, bus.hdr_err, 66'd0);
        chk({nm, "_locked"}, bus.locked, 66'd0);
        chk({nm, "_lock_offset"}, bus.lock_offset, 66'd0);
        chk({nm, "_relock_cnt"}, bus.relock_cnt, 66'd0);
    endtask

    task automatic send_block(input int off, input int gc, input bit good);
        logic [193:0] b;
        logic [65:0]  eb;
        logic [1:0]   hdr;
        exp_t         e;
        int           eo, h;
        bit           was_locked;
        for (int i = 0; i < 194; i++) b[i] = 1'($urandom_range(0, 1));
        eo  = (m_state == 2) ? m_lockoff : off;
        h   = 128 - gc + eo;
        hdr = good ? (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10)
                   : (($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11);
        b[h]     = hdr[1];
        b[h - 1] = hdr[0];
        for (int i = 0; i < 66; i++) eb[i] = b[h - 65 + i];

        was_locked = (m_state == 2);
        case (m_state)
            0: if (good) begin m_good = 1; m_cand = eo; m_state = 1; end
            1: begin
                if (!good) begin
                    m_state = 0; m_good = 0;
                end else begin
                    if (eo != m_cand) begin m_good = 1; m_cand = eo; end
                    else m_good++;
                    if (m_good >= LOCK_GOOD) begin
                        m_state = 2; m_lockoff = m_cand; m_win = 0; m_bad = 0;
                    end
                end
            end
            default: begin
                m_win++;
                if (!good) m_bad++;
                if (m_bad == UNLOCK_BAD) begin
                    m_state = 0; m_good = 0; m_win = 0; m_bad = 0;
                    if (m_relock < 255) m_relock++;
                end else if (m_win == UNLOCK_WIN) begin
                    m_win = 0; m_bad = 0;
                end
            end
        endcase
        e.dv      = was_locked || (m_state == 2);
        e.blk     = eb;
        e.err     = !good;
        e.locked  = (m_state == 2);
        e.lockoff = 7'(m_lockoff);
        e.relock  = 8'(m_relock);
        sb.push_back(e);

        @(negedge clk);
        bus.gbox_buffer  = b;
        bus.gbox_cnt     = 6'(gc);
        bus.block_offset = 7'(off);
        bus.buffer_dv    = 1'b1;
        @(negedge clk);
        bus.buffer_dv = 1'b0;
        chk("dv_early", bus.block_dv, 66'd0);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 66'd1, 66'd0);
        end else begin
            e = sb.pop_front();
            chk("block_dv", bus.block_dv, e.dv);
            chk("block_o", bus.block_o, e.blk);
            chk("hdr_err", bus.hdr_err, e.err);
            chk("locked", bus.locked, e.locked);
            chk("lock_offset", bus.lock_offset, e.lockoff);
            chk("relock_cnt", bus.relock_cnt, e.relock);
        end
        @(negedge clk);
        chk("dv_pulse", bus.block_dv, 66'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_seg(input int idx);
        seg_t s;
        s = segs[idx];
        for (int k = 1; k <= s.n; k++) begin
            send_block(s.off, s.gc, !(k >= s.bad_lo && k <= s.bad_hi && s.bad_lo > 0));
        end
        chk($sformatf("seg%0d_locked", idx), bus.locked, 66'(s.exp_locked));
        chk($sformatf("seg%0d_lock_offset", idx), bus.lock_offset, 66'(s.exp_lockoff));
        chk($sformatf("seg%0d_relock_cnt", idx), bus.relock_cnt, 66'(s.exp_relock));
    endtask

    initial begin
        //            n   off gc bad_lo bad_hi locked lockoff relock
        segs[0] = '{  2, 65,  0,  0,  0, 1'b0,  0, 0};  // h = 193
        segs[1] = '{  2,  0, 63,  2,  2, 1'b0,  0, 0};  // h = 65, back to HUNT
        segs[2] = '{ 64, 10,  0,  0,  0, 1'b1, 10, 0};  // clean lock
        segs[3] = '{ 30, 10,  0,  0,  0, 1'b0,  0, 0};  // partial count
        segs[4] = '{ 64, 12,  5,  0,  0, 1'b1, 12, 0};  // seeker moved
        segs[5] = '{ 64, 12,  7,  1, 15, 1'b1, 12, 0};  // 15 bad: hold
        segs[6] = '{ 16, 12,  7,  1, 16, 1'b0, 12, 1};  // 16 bad: unlock
        segs[7] = '{ 64, 20,  3,  0,  0, 1'b1, 20, 1};  // relock
        segs[8] = '{ 64,  5,  3, 55, 64, 1'b1, 20, 1};  // offset ignored
        segs[9] = '{ 20,  5,  3,  1, 10, 1'b1, 20, 1};  // window reset

        model_reset();
        bus.gbox_buffer  = '0;
        bus.gbox_cnt     = '0;
        bus.block_offset = '0;
        bus.buffer_dv    = 1'b1;
        rst              = 1'b1;
        @(negedge clk);
        check_idle("rst_c1");
        bus.buffer_dv = 1'b0;
        @(negedge clk);
        check_idle("rst_c2");
        bus.buffer_dv = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        bus.buffer_dv = 1'b0;
        chk("post_rst_dv1", bus.block_dv, 66'd0);
        @(negedge clk);
        chk("post_rst_dv2", bus.block_dv, 66'd0);
        // the block accepted on the release cycle reaches stage 2 in HUNT
        chk("post_rst_locked", bus.locked, 66'd0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) run_seg(i);

        // Reset mid-lock with a block already in stage 1
        bus.buffer_dv = 1'b1;
        @(negedge clk);
        bus.buffer_dv = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_rst");
        model_reset();
        @(negedge clk);
        chk("mid_rst_drop", bus.block_dv, 66'd0);
        repeat (3) @(negedge clk);

        for (int i = 3; i < 10; i++) run_seg(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
